// File: rtl/dwt_pkg.sv
// Shared types and constants for the multi-level 2D DWT pass scheduler.
// Optional stall counter is enabled with DWT_PERF_CNT_EN.
package dwt_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ROW,
        ROW_DRAIN,
        COL,
        COL_DRAIN,
        DONE
    } state_e;

    localparam logic BANK_IN  = 1'b0;
    localparam logic BANK_TMP = 1'b1;

    function automatic int addr_w(input int w, input int h);
        return $clog2(w * h);
    endfunction

endpackage

// File: rtl/dwt_addr_gen.sv
// Pixel/line pointer pair with wrap logic and pair address generation.
// WR_SIDE selects the coefficient write-back layout instead of the read layout.
module dwt_addr_gen
    import dwt_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int HEIGHT  = 16,
    parameter bit WR_SIDE = 1'b0,
    localparam int AW     = addr_w(WIDTH, HEIGHT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          adv_i,
    input  logic          mode_i,
    input  logic [2:0]    level_i,
    output logic [AW-1:0] addr1_o,
    output logic [AW-1:0] addr2_o
);

    localparam int LW = $clog2(WIDTH);

    logic [AW-1:0] p_q, p_d;
    logic [AW-1:0] c_q, c_d;
    logic [AW-1:0] wl, hl, len, lines;
    logic          p_last, c_last;

    assign wl     = AW'(WIDTH) >> level_i;
    assign hl     = AW'(HEIGHT) >> level_i;
    assign len    = mode_i ? hl : wl;
    assign lines  = mode_i ? wl : hl;
    assign p_last = (p_q == len - AW'(2));
    assign c_last = (c_q == lines - AW'(1));

    always_comb begin
        p_d = p_q;
        c_d = c_q;
        if (clr_i) begin
            p_d = '0;
            c_d = '0;
        end else if (adv_i) begin
            if (p_last) begin
                p_d = '0;
                c_d = c_last ? '0 : c_q + AW'(1);
            end else begin
                p_d = p_q + AW'(2);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            p_q <= '0;
            c_q <= '0;
        end else begin
            p_q <= p_d;
            c_q <= c_d;
        end
    end

    // Write side packs lows into the first half of the line, highs after.
    if (WR_SIDE) begin : g_wr
        logic [AW-1:0] half;
        assign half = p_q >> 1;
        always_comb begin
            if (!mode_i) begin
                addr1_o = (c_q << LW) + half;
                addr2_o = (c_q << LW) + half + (wl >> 1);
            end else begin
                addr1_o = (half << LW) + c_q;
                addr2_o = ((half + (hl >> 1)) << LW) + c_q;
            end
        end
    end else begin : g_rd
        always_comb begin
            if (!mode_i) begin
                addr1_o = (c_q << LW) + p_q;
                addr2_o = (c_q << LW) + p_q + AW'(1);
            end else begin
                addr1_o = (p_q << LW) + c_q;
                addr2_o = ((p_q + AW'(1)) << LW) + c_q;
            end
        end
    end

endmodule

// File: rtl/dwt_pass_scheduler.sv
// Multi-level 2D DWT pass sequencer over two ping-pong banks.
// Define DWT_PERF_CNT_EN to build the stall_cycles counter.
module dwt_pass_scheduler
    import dwt_pkg::*;
#(
    parameter int WIDTH           = 16,
    parameter int HEIGHT          = 16,
    parameter int LEVELS          = 1,
    parameter int MAX_OUTSTANDING = 4,
    localparam int AW             = addr_w(WIDTH, HEIGHT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [2:0]    cur_level,
    output logic          cur_mode,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic          rd_bank,
    output logic [AW-1:0] rd_addr1,
    output logic [AW-1:0] rd_addr2,
    input  logic          res_valid,
    output logic          wr_en,
    output logic          wr_bank,
    output logic [AW-1:0] wr_addr1,
    output logic [AW-1:0] wr_addr2,
    output logic          err,
    output logic [31:0]   stall_cycles
);

    localparam int         LW      = $clog2(WIDTH);
    localparam logic [2:0] LAST_LV = 3'(LEVELS - 1);

    state_e        state_q;
    logic [2:0]    level_q;
    logic          busy_q, done_q, err_q;
    logic [3:0]    out_q, out_d;
    logic          issuing, in_pass, acc, res_ok;
    logic          start_acc, rd_last;
    logic [AW-1:0] wl, hl, last_a;

    assign issuing   = (state_q == ROW) || (state_q == COL);
    assign in_pass   = issuing || (state_q == ROW_DRAIN)
                     || (state_q == COL_DRAIN);
    assign cur_mode  = (state_q == COL) || (state_q == COL_DRAIN);
    assign rd_valid  = issuing && (out_q < 4'(MAX_OUTSTANDING));
    assign acc       = rd_valid && rd_ready;
    assign res_ok    = res_valid && in_pass && (out_q != '0);
    assign start_acc = (state_q == IDLE) && start;

    assign wr_en     = res_ok;
    assign rd_bank   = cur_mode ? BANK_TMP : BANK_IN;
    assign wr_bank   = ~rd_bank;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cur_level = level_q;
    assign err       = err_q;

    // Final pair of a pass is identified by its unique first read address.
    assign wl     = AW'(WIDTH) >> level_q;
    assign hl     = AW'(HEIGHT) >> level_q;
    assign last_a = cur_mode
                  ? ((hl - AW'(2)) << LW) + wl - AW'(1)
                  : ((hl - AW'(1)) << LW) + wl - AW'(2);
    assign rd_last = acc && (rd_addr1 == last_a);

    dwt_addr_gen #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .WR_SIDE(1'b0)
    ) u_rd_gen (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (start_acc),
        .adv_i  (acc),
        .mode_i (cur_mode),
        .level_i(level_q),
        .addr1_o(rd_addr1),
        .addr2_o(rd_addr2)
    );

    dwt_addr_gen #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT),
        .WR_SIDE(1'b1)
    ) u_wr_gen (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (start_acc),
        .adv_i  (res_ok),
        .mode_i (cur_mode),
        .level_i(level_q),
        .addr1_o(wr_addr1),
        .addr2_o(wr_addr2)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            level_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= ROW;
                        level_q <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ROW: begin
                    if (rd_last) state_q <= ROW_DRAIN;
                end
                ROW_DRAIN: begin
                    if (out_q == '0) state_q <= COL;
                end
                COL: begin
                    if (rd_last) state_q <= COL_DRAIN;
                end
                COL_DRAIN: begin
                    if (out_q == '0) begin
                        if (level_q != LAST_LV) begin
                            state_q <= ROW;
                            level_q <= level_q + 3'd1;
                        end else begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        out_d = out_q;
        unique case ({acc, res_ok})
            2'b10:   out_d = out_q + 4'd1;
            2'b01:   out_d = out_q - 4'd1;
            default: out_d = out_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_q <= '0;
            err_q <= 1'b0;
        end else begin
            out_q <= out_d;
            if (res_valid && !res_ok) err_q <= 1'b1;
        end
    end

`ifdef DWT_PERF_CNT_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (start_acc) begin
            stall_d = '0;
        end else if (busy_q && !acc && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) stall_q <= '0;
        else      stall_q <= stall_d;
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_dwt_pass_scheduler.sv
// Scoreboard bench for dwt_pass_scheduler: loop-built reference sequence,
// random MAC latency and rd_ready backpressure, error and reset cases.
module tb_dwt_pass_scheduler;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int LV = 2;
    localparam int MO = 2;
    localparam int AW = $clog2(W * H);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          rd_ready = 1'b0;
    logic          res_valid = 1'b0;
    logic          busy, done, cur_mode, rd_valid, rd_bank;
    logic          wr_en, wr_bank, err;
    logic [2:0]    cur_level;
    logic [AW-1:0] rd_addr1, rd_addr2, wr_addr1, wr_addr2;
    logic [31:0]   stall_cycles;

    always #5 clk = ~clk;

    dwt_pass_scheduler #(
        .WIDTH(W), .HEIGHT(H), .LEVELS(LV), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .busy(busy), .done(done),
        .cur_level(cur_level), .cur_mode(cur_mode),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_bank(rd_bank),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .res_valid(res_valid), .wr_en(wr_en), .wr_bank(wr_bank),
        .wr_addr1(wr_addr1), .wr_addr2(wr_addr2),
        .err(err), .stall_cycles(stall_cycles)
    );

    typedef struct packed {
        logic          bk;
        logic [2:0]    lv;
        logic          md;
        logic [AW-1:0] a1;
        logic [AW-1:0] a2;
    } rd_t;

    typedef struct packed {
        logic          bk;
        logic [AW-1:0] a1;
        logic [AW-1:0] a2;
    } wr_t;

    rd_t exp_rd[$];
    wr_t exp_wr[$];
    int  pend[$];

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int n_acc = 0;
    int n_wr = 0;
    int exp_total = 0;
    int lat_lo = 2;
    int lat_hi = 2;
    bit rnd_ready = 1'b0;
    bit hold = 1'b0;
    bit mac_off = 1'b0;
    bit inj = 1'b0;
    bit mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic fail(input string nm);
        n_chk++;
        $display("FAIL %s: got unexpected event, expected none", nm);
    endtask

    // Reference: every level does a row pass then a column pass,
    // lines outer, pixel pairs inner; results return in issue order.
    task automatic build_model();
        rd_t r;
        wr_t w;
        exp_rd.delete();
        exp_wr.delete();
        for (int lv = 0; lv < LV; lv++) begin
            for (int md = 0; md < 2; md++) begin
                int wl, hl, len, lines;
                wl    = W >> lv;
                hl    = H >> lv;
                len   = (md == 1) ? hl : wl;
                lines = (md == 1) ? wl : hl;
                for (int c = 0; c < lines; c++) begin
                    for (int p = 0; p < len; p += 2) begin
                        r.bk = (md == 1);
                        r.lv = 3'(lv);
                        r.md = (md == 1);
                        w.bk = (md == 0);
                        if (md == 0) begin
                            r.a1 = AW'(c * W + p);
                            r.a2 = AW'(c * W + p + 1);
                            w.a1 = AW'(c * W + p / 2);
                            w.a2 = AW'(c * W + p / 2 + wl / 2);
                        end else begin
                            r.a1 = AW'(p * W + c);
                            r.a2 = AW'((p + 1) * W + c);
                            w.a1 = AW'((p / 2) * W + c);
                            w.a2 = AW'((p / 2 + hl / 2) * W + c);
                        end
                        exp_rd.push_back(r);
                        exp_wr.push_back(w);
                    end
                end
            end
        end
        exp_total = exp_rd.size();
    endtask

    // MAC model: queues due cycles on accept, returns pairs in order.
    initial begin
        forever begin
            @(negedge clk);
            if (rd_valid && rd_ready && !mac_off)
                pend.push_back(cyc + int'($urandom_range(lat_hi, lat_lo)));
            if (res_valid && !inj && pend.size() > 0)
                void'(pend.pop_front());
            @(posedge clk);
            #1;
            rd_ready  = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            res_valid = inj || (!mac_off && !hold && pend.size() > 0
                                && pend[0] <= cyc);
        end
    end

    // Monitor: pops the scoreboard on every accepted read and write strobe.
    initial begin
        rd_t last_rd;
        bit  stalled;
        stalled = 1'b0;
        last_rd = '0;
        forever begin
            @(negedge clk);
            if (mon_en && rst) begin
                if (stalled) begin
                    check("rd_hold_valid", 64'(rd_valid), 64'd1);
                    check("rd_hold_addr", {rd_addr1, rd_addr2},
                          {last_rd.a1, last_rd.a2});
                end
                stalled = 1'b0;
                if (rd_valid && rd_ready) begin
                    n_acc++;
                    if (exp_rd.size() == 0) fail("rd_extra");
                    else check("rd_req", {rd_bank, cur_level, cur_mode,
                                          rd_addr1, rd_addr2},
                               exp_rd.pop_front());
                end else if (rd_valid) begin
                    stalled = 1'b1;
                    last_rd = {rd_bank, cur_level, cur_mode,
                               rd_addr1, rd_addr2};
                end
                if (wr_en) begin
                    n_wr++;
                    if (exp_wr.size() == 0) fail("wr_extra");
                    else check("wr_pair", {wr_bank, wr_addr1, wr_addr2},
                               exp_wr.pop_front());
                end
            end else begin
                stalled = 1'b0;
            end
        end
    end

    task automatic start_x();
        build_model();
        n_acc = 0;
        n_wr  = 0;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input bit poke, output int bc, output bit ok);
        bc = 0;
        ok = 1'b0;
        for (int i = 0; i < 4000 && !ok; i++) begin
            @(negedge clk);
            if (done) ok = 1'b1;
            else bc++;
            if (poke && i == 6) start = 1'b1;
            if (poke && i == 7) start = 1'b0;
        end
    endtask

    task automatic end_checks(input string nm, input bit ok, input int bc,
                              input bit chk_perf);
        check({nm, "_done"}, 64'(ok), 64'd1);
        check({nm, "_busy_at_done"}, 64'(busy), 64'd0);
        check({nm, "_acc_cnt"}, 64'(n_acc), 64'(exp_total));
        check({nm, "_wr_cnt"}, 64'(n_wr), 64'(exp_total));
        if (chk_perf) begin
`ifdef DWT_PERF_CNT_EN
            check({nm, "_stall"}, 64'(stall_cycles), 64'(bc - n_acc));
`else
            check({nm, "_stall"}, 64'(stall_cycles), 64'(bc - bc));
`endif
        end
        @(negedge clk);
        check({nm, "_done_pulse"}, 64'(done), 64'd0);
        check({nm, "_idle_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int bc;
        bit ok;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_rd_valid", 64'(rd_valid), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_level", 64'(cur_level), 64'd0);
        check("rst_mode", 64'(cur_mode), 64'd0);
        check("rst_bank", 64'(rd_bank), 64'd0);
        check("rst_stall", 64'(stall_cycles), 64'd0);
        rst = 1'b1;
        mon_en = 1'b1;

        // Fixed latency, no backpressure; stray start mid-run is ignored.
        lat_lo = 2; lat_hi = 2; rnd_ready = 1'b0;
        start_x();
        wait_done(1'b1, bc, ok);
        end_checks("fixed", ok, bc, 1'b1);

        // Random latency and random rd_ready.
        lat_lo = 2; lat_hi = 5; rnd_ready = 1'b1;
        start_x();
        wait_done(1'b0, bc, ok);
        end_checks("stall", ok, bc, 1'b1);
        rnd_ready = 1'b0;

        // Results withheld: issue stops at the outstanding limit.
        lat_lo = 2; lat_hi = 2; hold = 1'b1;
        start_x();
        repeat (8) @(negedge clk);
        check("hold_acc", 64'(n_acc), 64'(MO));
        check("hold_rd_valid", 64'(rd_valid), 64'd0);
        hold = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (res_valid) ok = 1'b1;
        end
        check("hold_res_seen", 64'(ok), 64'd1);
        check("hold_rdv_at_res", 64'(rd_valid), 64'd0);
        @(negedge clk);
        check("hold_rdv_resume", 64'(rd_valid), 64'd1);
        wait_done(1'b0, bc, ok);
        end_checks("hold", ok, bc, 1'b0);

        // Stray result while idle.
        check("err_pre", 64'(err), 64'd0);
        inj = 1'b1;
        @(negedge clk);
        check("inj_wr_en", 64'(wr_en), 64'd0);
        inj = 1'b0;
        @(negedge clk);
        check("inj_err", 64'(err), 64'd1);

        // Reset during a column pass.
        lat_lo = 2; lat_hi = 3;
        start_x();
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (cur_mode) ok = 1'b1;
        end
        check("reach_col", 64'(ok), 64'd1);
        mac_off = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_rd_valid", 64'(rd_valid), 64'd0);
        check("abort_err", 64'(err), 64'd0);
        check("abort_level", 64'(cur_level), 64'd0);
        check("abort_mode", 64'(cur_mode), 64'd0);
        check("abort_bank", 64'(rd_bank), 64'd0);
        check("abort_wr_en", 64'(wr_en), 64'd0);
        check("abort_stall", 64'(stall_cycles), 64'd0);
        pend.delete();
        exp_rd.delete();
        exp_wr.delete();
        rst = 1'b1;
        mac_off = 1'b0;

        // Full transform after the abort.
        lat_lo = 2; lat_hi = 2;
        start_x();
        wait_done(1'b0, bc, ok);
        end_checks("recover", ok, bc, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
